// File: rtl/error_injector.sv
// Error-injection engine for the EDC data cache: reads a word, corrupts it
// with a fixed or LFSR-chosen fault pattern and writes it back.
// Ports:
//   clk, rst (async active-low)
//   start/abort/mode/base_addr/count/period/dmask/pmask/seed: run control
//   rd_en/rd_addr/rd_data/rd_par: cache read port
//   error_dwe/error_pwe/error_din/error_pin/error_addr: cache write port
//   busy/done/inj_count: run status
module error_injector #(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 7,
  parameter int ADDR_W = 9,
  parameter int GAP_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [GAP_W-1:0]  period,
  input  logic [DATA_W-1:0] dmask,
  input  logic [PAR_W-1:0]  pmask,
  input  logic [15:0]       seed,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [PAR_W-1:0]  rd_par,
  output logic              error_dwe,
  output logic              error_pwe,
  output logic [DATA_W-1:0] error_din,
  output logic [PAR_W-1:0]  error_pin,
  output logic [ADDR_W-1:0] error_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   inj_count
);

  localparam int TOT = DATA_W + PAR_W;
  localparam logic [31:0] TOT_U = 32'(TOT);
  localparam logic [TOT-1:0] ONE = TOT'(1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_WR, S_GAP, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] dmask_q, dmask_d;
  logic [PAR_W-1:0]  pmask_q, pmask_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [GAP_W-1:0]  period_q, period_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [ADDR_W:0]   inj_q, inj_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              dwe_q, dwe_d;
  logic              pwe_q, pwe_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [PAR_W-1:0]  pin_q, pin_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       b1, b2;
  logic [TOT-1:0]    flip;
  logic [DATA_W-1:0] em_d;
  logic [PAR_W-1:0]  em_p;
  logic [15:0]       lfsr_nxt;

  assign lfsr_nxt = {lfsr_q[14:0],
    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Effective masks: every mode reduces to stored ^ em.
  // Stuck-at-1 only flips bits that are currently 0.
  always_comb begin
    b1 = 32'(lfsr_q) % TOT_U;
    b2 = (b1 + 32'd1 +
      (32'(lfsr_q[15:8]) % (TOT_U - 32'd1))) % TOT_U;
    flip = ONE << b1;
    if (mode_q == 2'd2) flip = flip | (ONE << b2);
    em_d = flip[DATA_W-1:0];
    em_p = flip[TOT-1:DATA_W];
    unique case (1'b1)
      mode_q == 2'd0: begin
        em_d = dmask_q;
        em_p = pmask_q;
      end
      mode_q == 2'd3: begin
        em_d = dmask_q & ~rd_data;
        em_p = pmask_q & ~rd_par;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dmask_d  = dmask_q;
    pmask_d  = pmask_q;
    count_d  = count_q;
    period_d = period_q;
    gap_d    = gap_q;
    addr_d   = addr_q;
    lfsr_d   = lfsr_q;
    inj_d    = inj_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d   = mode;
          dmask_d  = dmask;
          pmask_d  = pmask;
          count_d  = count;
          period_d = period;
          addr_d   = base_addr;
          lfsr_d   = (seed == 16'd0) ? LFSR_INIT : seed;
          inj_d    = '0;
          state_d  = (count == '0) ? S_DONE : S_RD;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = S_WR;
      S_WR: begin
        inj_d  = inj_q + (ADDR_W+1)'(1);
        lfsr_d = lfsr_nxt;
        addr_d = addr_q + ADDR_W'(1);
        gap_d  = period_q;
        if (inj_d == count_q) state_d = S_DONE;
        else if (period_q != '0) state_d = S_GAP;
        else state_d = S_RD;
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) state_d = S_RD;
        else gap_d = gap_q - GAP_W'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && abort) state_d = S_IDLE;

    // Outputs are registered from the next state.
    rd_en_d   = (state_d == S_RD);
    rd_addr_d = (state_d == S_RD) ? addr_d : '0;
    busy_d    = (state_d == S_RD) || (state_d == S_CAP) ||
                (state_d == S_WR) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
    dwe_d     = 1'b0;
    pwe_d     = 1'b0;
    din_d     = '0;
    pin_d     = '0;
    eaddr_d   = '0;
    if (state_d == S_WR) begin
      dwe_d   = |em_d;
      pwe_d   = |em_p;
      din_d   = rd_data ^ em_d;
      pin_d   = rd_par ^ em_p;
      eaddr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      dmask_q   <= '0;
      pmask_q   <= '0;
      count_q   <= '0;
      period_q  <= '0;
      gap_q     <= '0;
      addr_q    <= '0;
      lfsr_q    <= LFSR_INIT;
      inj_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      dwe_q     <= 1'b0;
      pwe_q     <= 1'b0;
      din_q     <= '0;
      pin_q     <= '0;
      eaddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dmask_q   <= dmask_d;
      pmask_q   <= pmask_d;
      count_q   <= count_d;
      period_q  <= period_d;
      gap_q     <= gap_d;
      addr_q    <= addr_d;
      lfsr_q    <= lfsr_d;
      inj_q     <= inj_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      dwe_q     <= dwe_d;
      pwe_q     <= pwe_d;
      din_q     <= din_d;
      pin_q     <= pin_d;
      eaddr_q   <= eaddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign error_dwe  = dwe_q;
  assign error_pwe  = pwe_q;
  assign error_din  = din_q;
  assign error_pin  = pin_q;
  assign error_addr = eaddr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign inj_count  = inj_q;

endmodule

// File: doc/error_injector.md
Name: error_injector

Overview:
- Hardware error-injection engine for the EDC-protected data cache; replaces ad-hoc testbench pokes on the cache error ports.
- Performs a read-modify-write: it reads the stored data/parity word, XORs or ORs in a fault pattern, and writes the result back through error_dwe/error_pwe/error_din/error_pin/error_addr.
- Supports fixed masks, random single-bit faults, random double-bit faults and stuck-at modes over an address range, with a programmable gap between injections.

Parameters:
- DATA_W, 32, data word width.
- PAR_W, 7, parity/check bits per word.
- ADDR_W, 9, cache word address width.
- GAP_W, 16, width of the inter-injection period counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; ignored while busy.
- abort  in  1  terminate the current run.
- mode  in  2  0=XOR mask, 1=random 1-bit, 2=random 2-bit, 3=stuck-at-1 (OR mask).
- base_addr  in  ADDR_W  first target address.
- count  in  ADDR_W+1  number of injections.
- period  in  GAP_W  idle cycles between injections.
- dmask  in  DATA_W  data fault mask (modes 0 and 3).
- pmask  in  PAR_W  parity fault mask (modes 0 and 3).
- seed  in  16  LFSR seed.
- rd_en  out  1  cache read strobe.
- rd_addr  out  ADDR_W  cache read address.
- rd_data  in  DATA_W  stored data; valid exactly 1 cycle after rd_en.
- rd_par  in  PAR_W  stored parity; valid exactly 1 cycle after rd_en.
- error_dwe  out  1  data write enable.
- error_pwe  out  1  parity write enable.
- error_din  out  DATA_W  corrupted data.
- error_pin  out  PAR_W  corrupted parity.
- error_addr  out  ADDR_W  write address.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes normally.
- inj_count  out  ADDR_W+1  injections completed in the current run.

Behaviour:
- Reset (rst=0, async):
  - All outputs go to 0, the FSM enters IDLE, and the LFSR is loaded with 16'hACE1.
- FSM states: IDLE, RD, CAP, WR, GAP, DONE. All outputs are registered.
- IDLE:
  - On start: latch mode, masks, count and period; set addr=base_addr, load LFSR=seed (seed 0 is replaced by 16'hACE1), clear inj_count, set busy=1.
  - If count=0, go to DONE; otherwise go to RD.
- RD: rd_en=1, rd_addr=addr; go to CAP.
- CAP: capture rd_data/rd_par; compute the effective masks em_d/em_p; go to WR.
- Effective masks by mode:
  - Mode 0: em=dmask/pmask; write value = stored XOR em.
  - Mode 3: write value = stored OR dmask/pmask; em = the bits that actually change.
  - Mode 1: b = lfsr mod (DATA_W+PAR_W). Bits 0..DATA_W-1 select data bits; the remaining bits select parity bit b-DATA_W. Write value is XOR.
  - Mode 2: b1 as in mode 1; b2 = (b1 + 1 + (lfsr[15:8] mod (TOT-1))) mod TOT, where TOT=DATA_W+PAR_W, so b2≠b1 always. Both bits are XORed.
- WR (one cycle):
  - error_addr=addr, error_din and error_pin = the corrupted words.
  - error_dwe = OR-reduce(em_d), error_pwe = OR-reduce(em_p). Either may be 0.
  - inj_count increments, the LFSR advances once (x^16+x^14+x^13+x^11+1, Fibonacci, shift left) and addr increments modulo 2^ADDR_W (wraps).
  - If inj_count+1==count go to DONE; else go to GAP if period>0, else RD.
- Outside WR, all error_* outputs are 0.
- GAP: counts down period cycles, then goes to RD.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE. inj_count holds its value until the next start.
- abort: sampled in any non-IDLE state; the next state is IDLE, busy drops and done is not pulsed. A WR cycle already visible completes; no further rd_en or error_* write follows.
- Simultaneous start and abort in IDLE: abort wins, the run does not begin.
- Timing: with start sampled at edge k, rd_en is high in cycle k+1, the write in cycle k+3 and done in cycle k+4. Each further injection costs 3+period cycles.

Test Plan:
- Mode 0, base_addr=1, count=1, dmask=32'h1, pmask=0, rd_data=32'h2 → one write at error_addr=1, error_din=32'h3, error_dwe=1, error_pwe=0; done at start+4; inj_count=1.
- Mode 0, base_addr=3, dmask=32'h4, pmask=7'b1000000, rd_par=7'b0000111 → error_din=rd_data^4, error_pin=7'b1000111, both enables=1.
- Mode 0, base_addr=9'h1FE, count=4, period=2 → writes at addresses 1FE, 1FF, 000, 001; consecutive writes 5 cycles apart; done after the 4th write.
- Mode 1 and mode 2, seed=16'h1234, count=32 → each write differs from the stored word in exactly 1 (mode 1) or exactly 2 (mode 2) bits across data+parity; the sequence is identical on rerun with the same seed.
- Mode 3, dmask=32'hF, rd_data=32'hF → em=0, no write enable asserted, inj_count still increments.
- Edge cases:
  - count=0 → done at start+1 with no rd_en.
  - abort in GAP → busy low next cycle, no done, no further writes.
  - rst pulsed low mid-WR → all outputs 0 immediately.
  - start while busy → ignored.
